fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads and
// buffers the returned words in a small prefetch FIFO whose head feeds IF/ID.
module fetch_unit #(
  parameter int                  WIDTH    = 16,
  parameter int                  PC_WIDTH = 16,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [WIDTH-1:0]    imem_rdata,
  output logic                instr_valid,
  output logic [WIDTH-1:0]    instr,
  output logic [PC_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                inflight_q, inflight_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;

  logic [WIDTH-1:0]    instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [CNT_W-1:0]    occupancy;
  logic                accept;
  logic                push;
  logic                pop;

  // The in-flight request holds a credit, so a returning word always finds a free slot.
  assign occupancy   = count_q + CNT_W'(inflight_q);
  assign imem_req    = ~reset & ~redirect & (occupancy < CNT_W'(DEPTH));
  assign imem_addr   = pc_q;
  assign accept      = imem_req & imem_ready;
  assign push        = imem_rvalid & inflight_q & ~redirect & ~reset;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & ~stall;
  assign instr       = instr_valid ? instr_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]    : '0;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (accept) begin
      pc_d       = pc_q + PC_WIDTH'(1);
      req_addr_d = pc_q;
      inflight_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A redirect flushes everything, including a pop or push in the same cycle.
    if (redirect) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count and pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a startup vector table, a transaction
// scoreboard with a one-cycle memory model, and directed corner sequences.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  fetch_unit #(
    .WIDTH(16), .PC_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
    int          rdy;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
  } vec_t;

  ent_t        sb[$];
  logic [15:0] popped[$];
  logic [15:0] m_pc;
  int          cyc;
  int          n_vec;
  int          n_err;

  logic        mem_pend;
  logic [15:0] mem_data;
  logic        stray_rvalid;

  logic        s_req;
  logic [15:0] s_addr;
  logic        s_valid;
  logic [15:0] s_pc;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample away from the edge, check, update model.
  task automatic tick();
    logic        exp_req;
    logic        exp_valid;
    logic        acc_model;
    logic        acc_mem;
    logic [15:0] addr_mem;
    imem_rvalid = mem_pend | stray_rvalid;
    imem_rdata  = mem_pend ? mem_data : 16'hBEEF;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;

    exp_req   = !reset && !redirect && (sb.size() < DEPTH);
    exp_valid = (sb.size() != 0) && (sb[0].rdy <= cyc);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      check("instr_pc", instr_pc, sb[0].pc);
      check("instr", instr, sb[0].data);
    end else begin
      check("instr_pc_empty", instr_pc, 32'h0);
      check("instr_empty", instr, 32'h0);
    end

    acc_mem   = imem_req & imem_ready;
    addr_mem  = imem_addr;
    acc_model = exp_req & imem_ready;

    if (reset) begin
      sb.delete();
      m_pc = RESET_PC;
    end else if (redirect) begin
      sb.delete();
      m_pc = redirect_pc;
    end else begin
      if (exp_valid && !stall) begin
        popped.push_back(sb[0].pc);
        void'(sb.pop_front());
      end
      if (acc_model) begin
        sb.push_back('{pc: m_pc, data: m_pc ^ 16'hA5A5, rdy: cyc + 2});
        m_pc = m_pc + 16'h1;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
    mem_pend = acc_mem;
    mem_data = addr_mem ^ 16'hA5A5;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    logic [3:0] pat;

    vecs[0] = '{rst: 1'b1, stl: 1'b0, req: 1'b0, addr: 16'h0, valid: 1'b0, pc: 16'h0};
    vecs[1] = '{rst: 1'b0, stl: 1'b0, req: 1'b1, addr: 16'h0, valid: 1'b0, pc: 16'h0};
    vecs[2] = '{rst: 1'b0, stl: 1'b0, req: 1'b1, addr: 16'h1, valid: 1'b0, pc: 16'h0};
    vecs[3] = '{rst: 1'b0, stl: 1'b0, req: 1'b1, addr: 16'h2, valid: 1'b1, pc: 16'h0};
    vecs[4] = '{rst: 1'b0, stl: 1'b0, req: 1'b1, addr: 16'h3, valid: 1'b1, pc: 16'h1};
    vecs[5] = '{rst: 1'b0, stl: 1'b1, req: 1'b1, addr: 16'h4, valid: 1'b1, pc: 16'h2};
    vecs[6] = '{rst: 1'b0, stl: 1'b1, req: 1'b1, addr: 16'h5, valid: 1'b1, pc: 16'h2};
    vecs[7] = '{rst: 1'b0, stl: 1'b1, req: 1'b0, addr: 16'h6, valid: 1'b1, pc: 16'h2};
    vecs[8] = '{rst: 1'b0, stl: 1'b0, req: 1'b0, addr: 16'h6, valid: 1'b1, pc: 16'h2};
    vecs[9] = '{rst: 1'b0, stl: 1'b0, req: 1'b1, addr: 16'h6, valid: 1'b1, pc: 16'h3};

    n_vec = 0; n_err = 0; cyc = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0;
    mem_pend = 1'b0; mem_data = 16'h0; stray_rvalid = 1'b0;
    m_pc = RESET_PC;
    @(posedge clk);
    @(negedge clk);

    // Startup, first fetch latency and a short stall fill from the vector table.
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst;
      stall = vecs[i].stl;
      tick();
      check("vec_req", s_req, vecs[i].req);
      if (vecs[i].req) check("vec_addr", s_addr, vecs[i].addr);
      check("vec_valid", s_valid, vecs[i].valid);
      check("vec_pc", s_pc, vecs[i].pc);
    end
    run(6);

    // Long stall: request must drop once the credits are exhausted.
    stall = 1'b1;
    run(8);
    check("stall_req_drop", s_req, 1'b0);
    stall = 1'b0;
    run(10);

    // Redirect with a response in flight.
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    check("redir_req_low", s_req, 1'b0);
    redirect = 1'b0;
    tick();
    check("redir_empty", s_valid, 1'b0);
    check("redir_addr", s_addr, 16'h0040);
    n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n++;
      if (s_valid) break;
    end
    check("redir_latency", n, 3);
    check("redir_first_pc", s_pc, 16'h0040);
    run(5);

    // Redirect while stalled with a full FIFO.
    stall = 1'b1;
    run(6);
    redirect = 1'b1; redirect_pc = 16'h0123;
    tick();
    redirect = 1'b0; stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_valid) break;
    end
    check("redir_stall_valid", s_valid, 1'b1);
    check("redir_stall_pc", s_pc, 16'h0123);
    run(4);

    // Memory backpressure pattern 1,0,0,1.
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      imem_ready = pat[i % 4];
      tick();
    end
    imem_ready = 1'b1;
    run(6);

    // Address wrap at the top of the PC space.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    popped.delete();
    run(8);
    check("wrap_count", (popped.size() >= 3), 1'b1);
    if (popped.size() >= 3) begin
      check("wrap_0", popped[0], 16'hFFFE);
      check("wrap_1", popped[1], 16'hFFFF);
      check("wrap_2", popped[2], 16'h0000);
    end

    // Reset mid-stream with three buffered entries and one request in flight.
    stall = 1'b1;
    run(2);
    check("pre_reset_valid", s_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0; stray_rvalid = 1'b1;
    tick();
    check("rst_valid", s_valid, 1'b0);
    check("rst_addr", s_addr, RESET_PC);
    stray_rvalid = 1'b0;
    popped.delete();
    run(6);
    check("rst_restart", (popped.size() != 0) ? popped[0] : 16'hDEAD, RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
